bram_port_sequencer: RTL
========================

Name: bram_port_sequencer

Overview:
Master for a single-port, no-change-mode block RAM port (en/we/addr/di in, 1-cycle registered do out). It turns burst commands into RAM port cycles: it streams write data into the RAM, or streams read data out of it under backpressure. It sits between a streaming client and a 64x16 single-port BRAM, and owns all en/we sequencing and read-latency bookkeeping.

Parameters:
AW, 6, RAM address width; burst length field width; depth 2**AW
DW, 16, RAM data width

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  burst start address
cmd_len  in  AW  burst length in words; 0 encodes 2**AW
wr_valid  in  1  write-data word offered
wr_ready  out  1  write-data word taken when wr_valid & wr_ready
wr_data  in  DW  write-data word
rd_valid  out  1  read word available
rd_ready  in  1  consumer takes word when rd_valid & rd_ready
rd_data  out  DW  read word
done  out  1  one-cycle pulse at burst completion
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_di  out  DW  RAM write data
ram_do  in  DW  RAM read data, valid the cycle after a read (en=1, we=0)

Behaviour:
- States: IDLE, WRITE, READ. Registers: addr (AW), remaining (AW+1), inflight (1), 2-entry output FIFO (occupancy 0..2).
- Reset (rst=1 at a clock edge): state=IDLE; addr=0; remaining=0; inflight=0; FIFO flushed. Reset values: cmd_ready=0 while rst is high, rd_valid=0, done=0, wr_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_di=0.
- Reset mid-burst aborts the burst. Read data returning the cycle after reset is discarded. No done pulse is issued.
- IDLE: cmd_ready=1. On accept: addr<=cmd_addr; remaining<=(cmd_len==0 ? 2**AW : cmd_len). Go to WRITE if cmd_write, else READ.
- cmd_ready=0 in WRITE and READ. A new command is accepted only in IDLE, even if the FIFO still holds data.
- WRITE:
  - wr_ready=1 combinationally.
  - ram_en=ram_we=wr_valid; ram_addr=addr; ram_di=wr_data (combinational pass-through).
  - Each accepted word: addr<=addr+1 (mod 2**AW), remaining<=remaining-1.
  - When the last word is accepted: go to IDLE, and done=1 on the next cycle.
  - wr_valid low inserts idle cycles with ram_en=0.
- READ:
  - wr_ready=0, ram_we=0.
  - Issue a read (ram_en=1, ram_addr=addr) when remaining>0 and (occupancy + inflight - pop) < 2, where pop = rd_valid & rd_ready this cycle.
  - Each issue: inflight<=1, addr++ (wraps), remaining--.
  - After the last issue: go to IDLE. That read still lands next cycle.
- Capture: when inflight=1, push ram_do into the FIFO and clear inflight (unless another read issues). A capture of the final word of a read burst raises done that same cycle.
- The credit rule guarantees a push never overflows. Full throughput is one word per cycle with rd_ready held high.
- No-change mode: ram_do is not consumed outside the capture cycle, so a write burst never corrupts FIFO contents.
- FIFO: rd_valid = occupancy>0; rd_data = head. Simultaneous push and pop leaves occupancy unchanged, with order preserved.
- Address wrap: addr 2**AW-1 is followed by 0 within a burst.
- Latencies:
  - cmd accept to first ram_en: 1 cycle.
  - Read issue to rd_valid: 2 cycles (1 RAM + 1 FIFO register).

Test Plan:
- Reset check: rst high for 3 cycles -> all outputs 0, cmd_ready=0. After release -> cmd_ready=1.
- Write burst: write addr=5, len=4, data 0xA000..0xA003, wr_valid continuous -> ram_we pulses at addr 5,6,7,8 with matching ram_di; done pulses 1 cycle after the 4th word. Then read addr=5, len=4 with rd_ready=1 -> rd_data 0xA000..0xA003 on 4 consecutive cycles, starting 2 cycles after the first issue.
- Wrap and len=0: write addr=62, len=0 (64 words, data=index) -> addresses 62,63,0,...,61. Readback of addr=0, len=2 -> 2, 3.
- Backpressure: read len=8 with rd_ready low for 5 cycles -> at most 2 reads issued, ram_en low afterwards. Release -> all 8 words in order, no duplicates or drops.
- Gapped write: wr_valid toggles every other cycle during a len=3 burst -> ram_en only on valid cycles; 3 writes total.
- Mid-burst reset: rst asserted in the cycle after a read issue of a len=6 burst -> FIFO empty and rd_valid=0 next cycle, no done. A new read command is accepted correctly after reset.

Source files
------------

// File: rtl/bram_port_sequencer_if.sv
// Client-side command/stream handshakes and single-port BRAM pins of the port sequencer.
// The master modport is the sequencer's view; slave is the client/RAM environment's view.
interface bram_port_sequencer_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;

    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;

    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    logic          done;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  ram_do,
        output cmd_ready, wr_ready, rd_valid, rd_data, done,
        output ram_en, ram_we, ram_addr, ram_di
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output ram_do,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done,
        input  ram_en, ram_we, ram_addr, ram_di
    );
endinterface

// File: rtl/bram_port_sequencer.sv
// Burst sequencer for a single-port no-change BRAM: streams writes in, streams reads out
// through a 2-entry skid FIFO sized by a credit rule so the 1-cycle RAM latency never overflows.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WRITE | one RAM write per accepted wr_data word
// READ  | issuing reads while remaining > 0 and FIFO credit is available
module bram_port_sequencer #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_port_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE_R = 1;
    localparam logic [AW-1:0] ONE_A = 1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic          inflight_q, inflight_d;
    logic          last_q, last_d;
    logic          done_wr_q, done_wr_d;

    logic [DW-1:0] fifo_q [2];
    logic          head_q, tail_q;
    logic [1:0]    occ_q;

    logic          push, pop, issue, last_word;
    logic [1:0]    credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        inflight_d    = 1'b0;
        last_d        = 1'b0;
        done_wr_d     = 1'b0;
        issue         = 1'b0;

        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_di    = '0;

        pop       = (occ_q != 2'd0) && bus.rd_ready;
        push      = inflight_q;
        // Words already owned by the FIFO (stored or landing) after this cycle's pop.
        credit    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        last_word = (remaining_q == ONE_R);

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_addr;
                    remaining_d = (bus.cmd_len == '0) ? DEPTH : {1'b0, bus.cmd_len};
                    state_d     = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                bus.ram_en   = bus.wr_valid;
                bus.ram_we   = bus.wr_valid;
                bus.ram_addr = addr_q;
                bus.ram_di   = bus.wr_data;
                if (bus.wr_valid) begin
                    addr_d      = addr_q + ONE_A;
                    remaining_d = remaining_q - ONE_R;
                    if (last_word) begin
                        state_d   = IDLE;
                        done_wr_d = 1'b1;
                    end
                end
            end
            READ: begin
                bus.ram_addr = addr_q;
                if ((remaining_q != '0) && (credit < 2'd2)) begin
                    issue       = 1'b1;
                    bus.ram_en  = 1'b1;
                    inflight_d  = 1'b1;
                    last_d      = last_word;
                    addr_d      = addr_q + ONE_A;
                    remaining_d = remaining_q - ONE_R;
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            bus.cmd_ready = 1'b0;
            bus.wr_ready  = 1'b0;
            bus.ram_en    = 1'b0;
            bus.ram_we    = 1'b0;
            bus.ram_addr  = '0;
            bus.ram_di    = '0;
            issue         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            last_q      <= 1'b0;
            done_wr_q   <= 1'b0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            last_q      <= last_d;
            done_wr_q   <= done_wr_d;
            if (push) begin
                tail_q <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[tail_q] <= bus.ram_do;
        end
    end

    assign bus.rd_valid = !rst && (occ_q != 2'd0);
    assign bus.rd_data  = fifo_q[head_q];
    assign bus.done     = !rst && (done_wr_q || (inflight_q && last_q));

endmodule
